// File: rtl/rans_enc_ctrl_if.sv
// Stream and core-side bundle for rans_enc_ctrl: symbol input, rANS core port and encoded-byte output.
// The slave modport is the controller's view; master is the surrounding environment.
interface rans_enc_ctrl_if #(
    parameter int SYMBOL_WIDTH = 8,
    parameter int RESOLUTION   = 10
);
    logic                        s_valid_i;
    logic [SYMBOL_WIDTH-1:0]     s_data_i;
    logic                        s_last_i;
    logic                        s_ready_o;

    logic                        enc_en_o;
    logic                        enc_freq_wr_o;
    logic                        enc_restart_o;
    logic [RESOLUTION-1:0]       enc_freq_o;
    logic [RESOLUTION-1:0]       enc_cum_freq_o;
    logic [SYMBOL_WIDTH-1:0]     enc_symb_o;
    logic                        enc_ready_i;
    logic [1:0]                  enc_valid_i;
    logic [2*SYMBOL_WIDTH-1:0]   enc_data_i;

    logic                        m_valid_o;
    logic [1:0]                  m_keep_o;
    logic [2*SYMBOL_WIDTH-1:0]   m_data_o;
    logic                        m_ready_i;

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, enc_ready_i, enc_valid_i, enc_data_i, m_ready_i,
        output s_ready_o, enc_en_o, enc_freq_wr_o, enc_restart_o, enc_freq_o, enc_cum_freq_o,
               enc_symb_o, m_valid_o, m_keep_o, m_data_o
    );

    modport master (
        output s_valid_i, s_data_i, s_last_i, enc_ready_i, enc_valid_i, enc_data_i, m_ready_i,
        input  s_ready_o, enc_en_o, enc_freq_wr_o, enc_restart_o, enc_freq_o, enc_cum_freq_o,
               enc_symb_o, m_valid_o, m_keep_o, m_data_o
    );
endinterface

// File: rtl/rans_enc_ctrl.sv
// Sequencer for the rANS encoder core: loads the frequency table, restarts the core, streams symbols
// under a credit scheme and buffers encoded bytes. Optional macro RANS_CTRL_SUMCHK_EN enables table checks.
module rans_enc_ctrl #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int ENC_LAT      = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    tbl_wr_i,
    input  logic [SYMBOL_WIDTH-1:0] tbl_addr_i,
    input  logic [RESOLUTION-1:0]   tbl_freq_i,
    input  logic                    start_i,
    rans_enc_ctrl_if.slave          bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);
    localparam int NSYM = 1 << SYMBOL_WIDTH;
    localparam int FW   = 2 + 2 * SYMBOL_WIDTH;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int IW   = $clog2(ENC_LAT + 1);
    localparam int OW   = ((CW > IW) ? CW : IW) + 1;
`ifdef RANS_CTRL_SUMCHK_EN
    localparam int ACC_W = RESOLUTION + 1;
`else
    localparam int ACC_W = RESOLUTION;
`endif

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_RESTART = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    logic [2:0]              state_reg, state_next;
    logic [SYMBOL_WIDTH-1:0] idx_reg;
    logic [ACC_W-1:0]        acc_reg;
    logic [RESOLUTION-1:0]   freq_mem [NSYM];
    logic [RESOLUTION-1:0]   cum_mem  [NSYM];
    logic [RESOLUTION-1:0]   ld_freq, run_freq, run_cum;
    logic [ENC_LAT-1:0]      infl_reg, infl_next;
    logic [IW-1:0]           infl_cnt;
    logic [OW-1:0]           occ;
    logic [FW-1:0]           fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]           head;
    logic [PW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]           count_reg;
    logic                    credit_ok, accept, issue, sum_ok;
    logic                    push, pop, fifo_full;

    assign ld_freq  = freq_mem[idx_reg];
    assign run_freq = freq_mem[bus.s_data_i];
    assign run_cum  = cum_mem[bus.s_data_i];

    // Table port is only writable while idle; cum entries are captured as LOAD walks the table.
    always_ff @(posedge clk_i) begin
        if (state_reg == ST_IDLE && tbl_wr_i)
            freq_mem[tbl_addr_i] <= tbl_freq_i;
    end

    always_ff @(posedge clk_i) begin
        if (state_reg == ST_LOAD)
            cum_mem[idx_reg] <= acc_reg[RESOLUTION-1:0];
    end

    // Credit: words in the FIFO plus words still inside the core must never exceed the depth.
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < ENC_LAT; i++)
            infl_cnt = infl_cnt + IW'(infl_reg[i]);
    end

    assign occ       = OW'(count_reg) + OW'(infl_cnt);
    assign credit_ok = occ < OW'(FIFO_DEPTH);
    assign accept    = (state_reg == ST_RUN) && bus.s_valid_i && bus.enc_ready_i && credit_ok;

`ifdef RANS_CTRL_SUMCHK_EN
    logic zero_sym;
    logic err_reg;
    assign zero_sym = (run_freq == '0);
    assign issue    = accept && !zero_sym;
    assign sum_ok   = (acc_reg == ACC_W'(1 << RESOLUTION));
    assign err_o    = err_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_reg <= 1'b0;
        else if (state_reg == ST_IDLE && start_i)
            err_reg <= 1'b0;
        else if ((state_reg == ST_CHECK && !sum_ok) || (accept && zero_sym))
            err_reg <= 1'b1;
    end
`else
    assign issue  = accept;
    assign sum_ok = 1'b1;
    assign err_o  = 1'b0;
`endif

    genvar gi;
    assign infl_next[0] = issue;
    for (gi = 1; gi < ENC_LAT; gi++) begin : g_infl
        assign infl_next[gi] = infl_reg[gi-1];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start_i) state_next = ST_LOAD;
            ST_LOAD:    if (&idx_reg) state_next = ST_CHECK;
            ST_CHECK:   state_next = sum_ok ? ST_RESTART : ST_DONE;
            ST_RESTART: state_next = ST_RUN;
            ST_RUN:     if (accept && bus.s_last_i) state_next = ST_DRAIN;
            ST_DRAIN:   if (infl_reg == '0 && count_reg == '0) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            acc_reg   <= '0;
            infl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            infl_reg  <= infl_next;
            if (state_reg == ST_IDLE && start_i) begin
                idx_reg <= '0;
                acc_reg <= '0;
            end else if (state_reg == ST_LOAD) begin
                idx_reg <= idx_reg + 1'b1;
                acc_reg <= acc_reg + ACC_W'(ld_freq);
            end
        end
    end

    // Core-facing drive: table words during LOAD, live symbol lookups during RUN.
    always_comb begin
        bus.enc_freq_wr_o  = 1'b0;
        bus.enc_restart_o  = 1'b0;
        bus.enc_en_o       = 1'b0;
        bus.s_ready_o      = 1'b0;
        bus.enc_symb_o     = '0;
        bus.enc_freq_o     = '0;
        bus.enc_cum_freq_o = '0;
        case (state_reg)
            ST_LOAD: begin
                bus.enc_freq_wr_o  = 1'b1;
                bus.enc_symb_o     = idx_reg;
                bus.enc_freq_o     = ld_freq;
                bus.enc_cum_freq_o = acc_reg[RESOLUTION-1:0];
            end
            ST_RESTART: bus.enc_restart_o = 1'b1;
            ST_RUN: begin
                bus.s_ready_o      = accept;
                bus.enc_en_o       = issue;
                bus.enc_symb_o     = bus.s_data_i;
                bus.enc_freq_o     = run_freq;
                bus.enc_cum_freq_o = run_cum;
            end
            default: ;
        endcase
    end

    assign busy_o = (state_reg != ST_IDLE);
    assign done_o = (state_reg == ST_DONE);

    assign push      = (bus.enc_valid_i != 2'b00);
    assign pop       = (count_reg != '0) && bus.m_ready_i;
    assign fifo_full = (count_reg == CW'(FIFO_DEPTH));

    always_ff @(posedge clk_i) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {bus.enc_valid_i, bus.enc_data_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    // Head is gated so the output bus reads zero while the buffer is empty.
    assign head         = fifo_mem[rd_ptr_reg];
    assign bus.m_valid_o = (count_reg != '0);
    assign bus.m_keep_o  = bus.m_valid_o ? head[FW-1 -: 2] : 2'b00;
    assign bus.m_data_o  = bus.m_valid_o ? head[FW-3:0] : '0;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full && !pop));
endmodule
